// File: rtl/accelerator_config_pkg.sv
// accelerator_config_pkg: shared accelerator configuration constants and types
package accelerator_config_pkg;
  localparam int PREFETCH_DEPTH = 4;
  typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_WAIT, P_DRAIN} pf_state_t;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: circular instruction buffer with wrapping pointers and occupancy count
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  // storage is not reset; empty-queue output is masked to zero instead
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // pointers wrap naturally at DEPTH because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  // head entry, zero while empty so stale storage never leaks out
  always_comb dout = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch-ahead FSM feeding a circular queue; PREFETCH_PERF_EN adds fetch/stall counters
module instr_prefetch_queue
  import accelerator_config_pkg::*;
#(
  parameter int INSTR_WIDTH = 64,
  parameter int DEPTH       = PREFETCH_DEPTH,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   fetch_en_o,
  input  logic                   fetch_done_i,
  input  logic [INSTR_WIDTH-1:0] fetch_instr_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic                   prog_done_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       count_o
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]            fetch_count_o,
  output logic [31:0]            stall_cycles_o
`endif
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  pf_state_t state, state_nxt;
  logic push, pop;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= P_IDLE;
    else state <= state_nxt;
  // next state; a zero instruction ends the program without being queued
  always_comb begin
    state_nxt = state;
    case (state)
      P_IDLE:  state_nxt = start ? P_ISSUE : P_IDLE;
      P_ISSUE: state_nxt = (count_o < FULL) ? P_WAIT : P_ISSUE;
      P_WAIT:  state_nxt = !fetch_done_i ? P_WAIT : (|fetch_instr_i) ? P_ISSUE : P_DRAIN;
      P_DRAIN: state_nxt = (count_o == '0) ? P_IDLE : P_DRAIN;
      default: state_nxt = P_IDLE;
    endcase
  end
  // outputs depend only on registered state and count; push/pop qualify the queue
  always_comb begin
    fetch_en_o    = (state == P_ISSUE) && (count_o < FULL);
    prog_done_o   = (state == P_DRAIN) && (count_o == '0);
    busy_o        = state != P_IDLE;
    instr_valid_o = count_o != '0;
    push          = (state == P_WAIT) && fetch_done_i && |fetch_instr_i;
    pop           = instr_valid_o && instr_ready_i;
  end
  instr_fifo #(.WIDTH(INSTR_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fetch_instr_i),
    .dout  (instr_o),
    .count (count_o)
  );
`ifdef PREFETCH_PERF_EN
  // saturating counters of queued instructions and full-queue issue stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_count_o  <= '0;
      stall_cycles_o <= '0;
    end else if (state == P_IDLE && start) begin
      fetch_count_o  <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (push && fetch_count_o != '1) fetch_count_o <= fetch_count_o + 32'd1;
      if (state == P_ISSUE && count_o == FULL && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + 32'd1;
    end
`endif
endmodule
